depacketizer: RTL and testbench

DEPACKETIZER -- requirements
Module: depacketizer

---
 rtl/depacketizer.sv | 152 +++++++++++++++
 tb/tb_depacketizer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/depacketizer.sv
// Packet FIFO depacketizer: pops 48-bit {TF, BF, HF} flits, validates the tail
// field and presents each good packet to a ready/valid downstream interface.
module depacketizer #(
   parameter logic [15:0] TAIL_MARKER    = 16'hFFFF,
   parameter bit          CHECK_TAIL     = 1'b1,
   parameter logic [15:0] PKT_COUNT_INIT = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [47:0] flit_in,
   input  logic        fifo_empty,
   output logic        read_enable,
   output logic [15:0] HF,
   output logic [15:0] BF,
   output logic [15:0] TF,
   output logic        data_valid,
   input  logic        data_ready,
   output logic [15:0] pkt_count,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic        pop_s;
   logic        load_s;
   logic        bad_s;
   logic        xfer_s;
   logic        flit_good_s;
   logic [15:0] hf_r;
   logic [15:0] bf_r;
   logic [15:0] tf_r;
   logic        data_valid_r;
   logic [15:0] pkt_count_r;
   logic [7:0]  err_count_r;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         sat_inc8 = 8'hFF;
      end else begin
         sat_inc8 = v + 8'd1;
      end
   endfunction

   // Next-state decode and per-cycle actions
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      load_s      = 1'b0;
      bad_s       = 1'b0;
      xfer_s      = 1'b0;
      flit_good_s = (!CHECK_TAIL) || (flit_in[47:32] == TAIL_MARKER);
      case (state_r)
         IDLE: begin
            if (!fifo_empty) begin
               pop_s       = 1'b1;
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FETCH: begin
            if (flit_good_s) begin
               load_s      = 1'b1;
               state_nxt_s = HOLD;
            end else begin
               bad_s       = 1'b1;
               state_nxt_s = IDLE;
            end
         end
         HOLD: begin
            if (data_valid_r && data_ready) begin
               xfer_s = 1'b1;
               if (!fifo_empty) begin
                  pop_s       = 1'b1;
                  state_nxt_s = FETCH;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Pop is gated by reset so a flit is never requested while the block is held
   assign read_enable = reset & pop_s;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Packet fields and valid flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         hf_r         <= 16'h0000;
         bf_r         <= 16'h0000;
         tf_r         <= 16'h0000;
         data_valid_r <= 1'b0;
      end else if (load_s) begin
         hf_r         <= flit_in[15:0];
         bf_r         <= flit_in[31:16];
         tf_r         <= flit_in[47:32];
         data_valid_r <= 1'b1;
      end else if (xfer_s) begin
         data_valid_r <= 1'b0;
      end else begin
         data_valid_r <= data_valid_r;
      end
   end

   // Delivered-packet (wrapping) and dropped-flit (saturating) counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         pkt_count_r <= PKT_COUNT_INIT;
         err_count_r <= 8'h00;
      end else begin
         if (xfer_s) begin
            pkt_count_r <= pkt_count_r + 16'd1;
         end else begin
            pkt_count_r <= pkt_count_r;
         end
         if (bad_s) begin
            err_count_r <= sat_inc8(err_count_r);
         end else begin
            err_count_r <= err_count_r;
         end
      end
   end

   assign HF         = hf_r;
   assign BF         = bf_r;
   assign TF         = tf_r;
   assign data_valid = data_valid_r;
   assign pkt_count  = pkt_count_r;
   assign err_count  = err_count_r;

endmodule

// File: tb/tb_depacketizer.sv
// Self-checking bench for depacketizer: transaction-level model compared every
// cycle, plus directed literal checks; a second instance covers CHECK_TAIL=0 and wrap.
module tb_depacketizer;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_ready;
   logic [47:0] flit_in, flit_in2;
   logic        fifo_empty, fifo_empty2;
   logic        read_enable, read_enable2;
   logic [15:0] HF, BF, TF, pkt_count;
   logic [15:0] HF2, BF2, TF2, pkt_count2;
   logic        data_valid, data_valid2;
   logic [7:0]  err_count, err_count2;

   int errors = 0;
   int checks = 0;
   int n;

   logic [47:0] q[$];
   logic [47:0] q2[$];

   // model: a flit in flight from the FIFO, a held packet, and the two counters
   logic        m_inflight = 1'b0;
   logic        m_valid    = 1'b0;
   logic [47:0] m_flit     = 48'h0;
   logic [15:0] m_pkts     = 16'h0;
   logic [7:0]  m_errs     = 8'h0;
   logic        exp_re, last_re, last_re2;

   always #5 clk = ~clk;

   depacketizer dut (
      .clk(clk), .reset(reset), .flit_in(flit_in), .fifo_empty(fifo_empty),
      .read_enable(read_enable), .HF(HF), .BF(BF), .TF(TF),
      .data_valid(data_valid), .data_ready(data_ready),
      .pkt_count(pkt_count), .err_count(err_count)
   );

   depacketizer #(.CHECK_TAIL(1'b0), .PKT_COUNT_INIT(16'hFFFE)) dut2 (
      .clk(clk), .reset(reset), .flit_in(flit_in2), .fifo_empty(fifo_empty2),
      .read_enable(read_enable2), .HF(HF2), .BF(BF2), .TF(TF2),
      .data_valid(data_valid2), .data_ready(data_ready),
      .pkt_count(pkt_count2), .err_count(err_count2)
   );

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: compare DUT against the model, advance model and FIFOs.
   task automatic cycle();
      logic        nx_inflight, nx_valid;
      logic [47:0] nx_flit;
      logic [15:0] nx_pkts;
      logic [7:0]  nx_errs;
      fifo_empty  = (q.size() == 0);
      fifo_empty2 = (q2.size() == 0);
      #1;
      exp_re = reset && !fifo_empty && !m_inflight && (!m_valid || data_ready);
      chk("read_enable", 48'(read_enable), 48'(exp_re));
      chk("data_valid",  48'(data_valid),  48'(m_valid));
      chk("HF",          48'(HF),          48'(m_flit[15:0]));
      chk("BF",          48'(BF),          48'(m_flit[31:16]));
      chk("TF",          48'(TF),          48'(m_flit[47:32]));
      chk("pkt_count",   48'(pkt_count),   48'(m_pkts));
      chk("err_count",   48'(err_count),   48'(m_errs));
      if (fifo_empty2 && read_enable2) chk("underflow2", 48'(read_enable2), 48'd0);
      last_re  = read_enable;
      last_re2 = read_enable2;
      nx_inflight = m_inflight;
      nx_valid    = m_valid;
      nx_flit     = m_flit;
      nx_pkts     = m_pkts;
      nx_errs     = m_errs;
      if (!reset) begin
         nx_inflight = 1'b0;
         nx_valid    = 1'b0;
         nx_flit     = 48'h0;
         nx_pkts     = 16'h0;
         nx_errs     = 8'h0;
      end else begin
         nx_inflight = exp_re;
         if (m_inflight) begin
            if (flit_in[47:32] == 16'hFFFF) begin
               nx_flit  = flit_in;
               nx_valid = 1'b1;
            end else if (m_errs != 8'hFF) begin
               nx_errs = m_errs + 8'd1;
            end
         end else if (m_valid && data_ready) begin
            nx_valid = 1'b0;
            nx_pkts  = m_pkts + 16'd1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      m_inflight = nx_inflight;
      m_valid    = nx_valid;
      m_flit     = nx_flit;
      m_pkts     = nx_pkts;
      m_errs     = nx_errs;
      if (exp_re) flit_in = q.pop_front();
      if (last_re2 && q2.size() > 0) flit_in2 = q2.pop_front();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; data_ready = 1'b0;
      flit_in = 48'h0; flit_in2 = 48'h0;
      fifo_empty = 1'b1; fifo_empty2 = 1'b1;
      repeat (2) @(negedge clk);
      repeat (3) cycle();
      chk("rst_pkt",  48'(pkt_count),  48'h0);
      chk("rst_err",  48'(err_count),  48'h0);
      chk("rst_dv",   48'(data_valid), 48'h0);
      chk("rst_hf",   48'(HF),         48'h0);
      chk("rst_pkt2", 48'(pkt_count2), 48'hFFFE);

      // empty FIFO: never a pop, never valid
      reset = 1'b1; data_ready = 1'b1; n = 0;
      repeat (20) begin cycle(); n += int'(last_re); end
      chk("empty_re_count", 48'(n), 48'd0);
      chk("empty_dv", 48'(data_valid), 48'd0);

      // single packet, 2-cycle latency
      q.push_back({16'hFFFF, 16'h1234, 16'hA5A5});
      cycle();
      chk("single_re", 48'(last_re), 48'd1);
      chk("single_dv_fetch", 48'(data_valid), 48'd0);
      cycle();
      chk("single_dv", 48'(data_valid), 48'd1);
      chk("single_hf", 48'(HF), 48'hA5A5);
      chk("single_bf", 48'(BF), 48'h1234);
      chk("single_tf", 48'(TF), 48'hFFFF);
      cycle();
      chk("single_dv_done", 48'(data_valid), 48'd0);
      chk("single_pkt", 48'(pkt_count), 48'd1);
      chk("single_hf_kept", 48'(HF), 48'hA5A5);

      // back-pressure: one pop while stalled, then one packet per 2 cycles
      data_ready = 1'b0;
      for (int i = 0; i < 3; i++) q.push_back({16'hFFFF, 16'h2000 + 16'(i), 16'h1000 + 16'(i)});
      n = 0;
      repeat (5) begin cycle(); n += int'(last_re); end
      chk("bp_pop_count", 48'(n), 48'd1);
      chk("bp_hf_stable", 48'(HF), 48'h1000);
      chk("bp_dv", 48'(data_valid), 48'd1);
      data_ready = 1'b1;
      repeat (6) cycle();
      chk("bp_pkt", 48'(pkt_count), 48'd4);
      chk("bp_hf_last", 48'(HF), 48'h1002);

      // bad tail dropped, FSM back in IDLE
      q.push_back({16'h0001, 16'hBEEF, 16'hCAFE});
      repeat (3) cycle();
      chk("bad_err", 48'(err_count), 48'd1);
      chk("bad_dv", 48'(data_valid), 48'd0);
      chk("bad_hf_kept", 48'(HF), 48'h1002);
      q.push_back({16'hFFFF, 16'h3333, 16'h4444});
      cycle();
      chk("bad_then_idle_re", 48'(last_re), 48'd1);
      repeat (3) cycle();
      chk("bad_then_pkt", 48'(pkt_count), 48'd5);
      chk("bad_then_hf", 48'(HF), 48'h4444);

      // reset during FETCH: in-flight flit discarded
      data_ready = 1'b0;
      q.push_back({16'hFFFF, 16'h0000, 16'h7777});
      q.push_back({16'hFFFF, 16'h0000, 16'h8888});
      cycle();
      reset = 1'b0;
      cycle();
      chk("rf_pkt", 48'(pkt_count), 48'd0);
      chk("rf_err", 48'(err_count), 48'd0);
      chk("rf_dv", 48'(data_valid), 48'd0);
      chk("rf_hf", 48'(HF), 48'd0);
      reset = 1'b1;
      repeat (3) cycle();
      chk("rf_next_hf", 48'(HF), 48'h8888);
      chk("rf_next_dv", 48'(data_valid), 48'd1);
      chk("rf_next_pkt", 48'(pkt_count), 48'd0);

      // reset during HOLD, with a pop otherwise due
      q.push_back({16'hFFFF, 16'h0000, 16'h9999});
      data_ready = 1'b1; reset = 1'b0;
      cycle();
      chk("rh_re", 48'(last_re), 48'd0);
      chk("rh_dv", 48'(data_valid), 48'd0);
      chk("rh_hf", 48'(HF), 48'd0);
      chk("rh_pkt", 48'(pkt_count), 48'd0);
      reset = 1'b1;
      repeat (3) cycle();
      chk("rh_after_pkt", 48'(pkt_count), 48'd1);
      chk("rh_after_hf", 48'(HF), 48'h9999);

      // err_count saturation
      reset = 1'b0; cycle(); reset = 1'b1;
      for (int i = 0; i < 260; i++) q.push_back({16'h0002, 16'(i), 16'(i)});
      repeat (524) cycle();
      chk("sat_err", 48'(err_count), 48'hFF);
      chk("sat_dv", 48'(data_valid), 48'd0);
      chk("sat_pkt", 48'(pkt_count), 48'd0);

      // CHECK_TAIL=0 accepts the bad tail; pkt_count wraps FFFF -> 0000
      data_ready = 1'b1;
      q2.push_back({16'h0001, 16'hBEEF, 16'hCAFE});
      q2.push_back({16'h0002, 16'h5555, 16'h6666});
      cycle();
      chk("nt_re", 48'(last_re2), 48'd1);
      cycle();
      chk("nt_dv", 48'(data_valid2), 48'd1);
      chk("nt_hf", 48'(HF2), 48'hCAFE);
      chk("nt_bf", 48'(BF2), 48'hBEEF);
      chk("nt_tf", 48'(TF2), 48'h0001);
      chk("nt_err", 48'(err_count2), 48'd0);
      cycle();
      chk("wrap_ffff", 48'(pkt_count2), 48'hFFFF);
      cycle();
      chk("nt_hf2", 48'(HF2), 48'h6666);
      chk("nt_dv2", 48'(data_valid2), 48'd1);
      cycle();
      chk("wrap_zero", 48'(pkt_count2), 48'h0000);
      chk("nt_dv_done", 48'(data_valid2), 48'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
